// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side request ports and SRAM-like bus ports of the memory bus arbiter.
// The arbiter uses the slave modport; the pipeline/bus environment uses master.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_data_ok;
  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_sel;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_data_ok;
  logic              bus_req;
  logic              bus_wr;
  logic [3:0]        bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;
  logic              busy;

  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_sel, data_addr, data_wdata,
           bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_rdata, inst_data_ok, data_rdata, data_data_ok,
           bus_req, bus_wr, bus_sel, bus_addr, bus_wdata, busy
  );

  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_sel, data_addr, data_wdata,
           bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_rdata, inst_data_ok, data_rdata, data_data_ok,
           bus_req, bus_wr, bus_sel, bus_addr, bus_wdata, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch and data ports: one transaction at a time,
// data has priority, and a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic             clk,
  input logic             rst,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state_r;
  logic [3:0]        starve_cnt_r;
  logic              owner_r;        // 1 = data port, 0 = fetch port
  logic              wr_r;
  logic [3:0]        sel_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              bus_req_r;
  logic              busy_r;
  logic              inst_ok_r;
  logic              data_ok_r;
  logic [DATA_W-1:0] inst_rdata_r;
  logic [DATA_W-1:0] data_rdata_r;

  logic       any_req_s;
  logic       grant_data_s;
  logic       capture_s;
  logic [3:0] starve_next_s;

  // Arbitration decision, next starvation count and bus completion detect
  always_comb begin
    any_req_s    = bus.inst_req | bus.data_req;
    grant_data_s = bus.data_req & ~(bus.inst_req & (starve_cnt_r == STARVE_LIM));
    if (grant_data_s && bus.inst_req) begin
      if (starve_cnt_r == STARVE_LIM) begin
        starve_next_s = starve_cnt_r;
      end else begin
        starve_next_s = starve_cnt_r + 4'd1;
      end
    end else begin
      starve_next_s = 4'd0;
    end
    case (state_r)
      S_ADDR:  capture_s = bus.bus_addr_ok & bus.bus_data_ok;
      S_DATA:  capture_s = bus.bus_data_ok;
      default: capture_s = 1'b0;
    endcase
  end

  // Transaction FSM, request latch, read-data capture and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      starve_cnt_r <= 4'd0;
      owner_r      <= 1'b0;
      wr_r         <= 1'b0;
      sel_r        <= 4'd0;
      addr_r       <= '0;
      wdata_r      <= '0;
      bus_req_r    <= 1'b0;
      busy_r       <= 1'b0;
      inst_ok_r    <= 1'b0;
      data_ok_r    <= 1'b0;
      inst_rdata_r <= '0;
      data_rdata_r <= '0;
    end else begin
      inst_ok_r <= 1'b0;
      data_ok_r <= 1'b0;
      if (capture_s) begin
        state_r   <= S_DONE;
        bus_req_r <= 1'b0;
        if (owner_r) begin
          data_ok_r <= 1'b1;
          if (!wr_r) begin
            data_rdata_r <= bus.bus_rdata;
          end
        end else begin
          inst_ok_r    <= 1'b1;
          inst_rdata_r <= bus.bus_rdata;
        end
      end else begin
        case (state_r)
          S_IDLE: begin
            if (any_req_s) begin
              owner_r      <= grant_data_s;
              wr_r         <= grant_data_s & bus.data_wr;
              sel_r        <= grant_data_s ? bus.data_sel : 4'b1111;
              addr_r       <= grant_data_s ? bus.data_addr : bus.inst_addr;
              wdata_r      <= grant_data_s ? bus.data_wdata : '0;
              starve_cnt_r <= starve_next_s;
              bus_req_r    <= 1'b1;
              busy_r       <= 1'b1;
              state_r      <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (bus.bus_addr_ok) begin
              bus_req_r <= 1'b0;
              state_r   <= S_DATA;
            end
          end
          // No timeout: the bus is trusted to eventually return data_ok
          S_DATA:  state_r <= S_DATA;
          S_DONE: begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
          default: begin
            bus_req_r <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.bus_req      = bus_req_r;
  assign bus.bus_wr       = wr_r;
  assign bus.bus_sel      = sel_r;
  assign bus.bus_addr     = addr_r;
  assign bus.bus_wdata    = wdata_r;
  assign bus.busy         = busy_r;
  assign bus.inst_data_ok = inst_ok_r;
  assign bus.data_data_ok = data_ok_r;
  assign bus.inst_rdata   = inst_rdata_r;
  assign bus.data_rdata   = data_rdata_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: request agents, a bus responder, a transaction-level
// reference model checked every cycle, and literal expectations for each scenario.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SMAX = 4;

  typedef struct {
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();
  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bus_val(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C08_8000;
    else return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- bus responder ----------------
  int   addr_wait = 0, data_wait = 0, same_cycle = 0;
  int   pend = -1, wcnt = 0, req_cycles = 0, last_req_cycles = 0;
  bit   addr_stable = 1'b1, last_addr_stable = 1'b1;
  logic [31:0] first_addr, pend_addr;
  txn_t bus_log[$];
  txn_t acc;

  initial begin
    ifc.bus_addr_ok = 1'b0;
    ifc.bus_data_ok = 1'b0;
    ifc.bus_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      ifc.bus_addr_ok = 1'b0;
      ifc.bus_data_ok = 1'b0;
      if (rst) begin
        pend = -1; wcnt = 0; req_cycles = 0;
      end else if (pend > 0) begin
        pend--;
      end else if (pend == 0) begin
        ifc.bus_data_ok = 1'b1;
        ifc.bus_rdata   = bus_val(pend_addr);
        pend = -1;
      end else if (ifc.bus_req) begin
        if (req_cycles == 0) begin
          first_addr  = ifc.bus_addr;
          addr_stable = 1'b1;
        end else if (ifc.bus_addr !== first_addr) begin
          addr_stable = 1'b0;
        end
        req_cycles++;
        if (wcnt < addr_wait) begin
          wcnt++;
        end else begin
          ifc.bus_addr_ok = 1'b1;
          acc.wr = ifc.bus_wr; acc.sel = ifc.bus_sel; acc.addr = ifc.bus_addr; acc.wdata = ifc.bus_wdata;
          bus_log.push_back(acc);
          last_req_cycles  = req_cycles;
          last_addr_stable = addr_stable;
          req_cycles = 0;
          wcnt = 0;
          if (same_cycle != 0) begin
            ifc.bus_data_ok = 1'b1;
            ifc.bus_rdata   = bus_val(ifc.bus_addr);
          end else begin
            pend      = data_wait;
            pend_addr = ifc.bus_addr;
          end
        end
      end
    end
  end

  // ---------------- request agents ----------------
  logic [31:0] iq[$];
  txn_t        dq[$];
  bit i_act = 1'b0, d_act = 1'b0, d_abort = 1'b0;
  int i_done = 0, d_done = 0, i_lat = 0, d_lat = 0;
  int i_start = 0, i_waitc = 0, d_start = 0, d_waitc = 0;
  txn_t d_cur;

  initial begin
    ifc.inst_req  = 1'b0;
    ifc.inst_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (i_act) begin
        i_waitc++;
        if (ifc.inst_data_ok) begin
          i_done++; i_lat = cyc - i_start; i_act = 1'b0; ifc.inst_req = 1'b0;
        end else if (i_waitc > 300) begin
          checks++; errors++;
          $display("FAIL inst_timeout actual=no_data_ok required=data_ok addr=0x%0h", ifc.inst_addr);
          i_act = 1'b0; ifc.inst_req = 1'b0;
        end
      end
      if (!i_act && iq.size() > 0) begin
        ifc.inst_addr = iq.pop_front();
        ifc.inst_req  = 1'b1;
        i_act = 1'b1; i_start = cyc; i_waitc = 0;
      end
    end
  end

  initial begin
    ifc.data_req = 1'b0; ifc.data_wr = 1'b0; ifc.data_sel = 4'h0;
    ifc.data_addr = 32'h0; ifc.data_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (d_act && d_abort) begin
        d_act = 1'b0; ifc.data_req = 1'b0;
      end else if (d_act) begin
        d_waitc++;
        if (ifc.data_data_ok) begin
          d_done++; d_lat = cyc - d_start; d_act = 1'b0; ifc.data_req = 1'b0;
        end else if (d_waitc > 300) begin
          checks++; errors++;
          $display("FAIL data_timeout actual=no_data_ok required=data_ok addr=0x%0h", ifc.data_addr);
          d_act = 1'b0; ifc.data_req = 1'b0;
        end
      end
      if (!d_act && !d_abort && dq.size() > 0) begin
        d_cur = dq.pop_front();
        ifc.data_wr = d_cur.wr; ifc.data_sel = d_cur.sel;
        ifc.data_addr = d_cur.addr; ifc.data_wdata = d_cur.wdata;
        ifc.data_req = 1'b1;
        d_act = 1'b1; d_start = cyc; d_waitc = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // phase: 0 no transaction, 1 address offered, 2 awaiting data, 3 completion visible
  int          m_phase = 0, m_starve = 0;
  bit          m_owner_data = 1'b0, m_take_data, m_iok = 1'b0, m_dok = 1'b0;
  txn_t        m_t;
  logic [31:0] m_irdata = 32'h0, m_drdata = 32'h0;

  task automatic m_complete();
    if (m_owner_data) begin
      m_dok = 1'b1;
      if (!m_t.wr) m_drdata = ifc.bus_rdata;
    end else begin
      m_iok = 1'b1;
      m_irdata = ifc.bus_rdata;
    end
    m_phase = 3;
  endtask

  initial begin
    m_t.wr = 1'b0; m_t.sel = 4'h0; m_t.addr = 32'h0; m_t.wdata = 32'h0;
    forever begin
      @(posedge clk);
      m_iok = 1'b0; m_dok = 1'b0;
      if (rst) begin
        m_phase = 0; m_starve = 0; m_owner_data = 1'b0;
        m_t.wr = 1'b0; m_t.sel = 4'h0; m_t.addr = 32'h0; m_t.wdata = 32'h0;
        m_irdata = 32'h0; m_drdata = 32'h0;
      end else if (m_phase == 0) begin
        if (ifc.inst_req || ifc.data_req) begin
          m_take_data = ifc.data_req && !(ifc.inst_req && m_starve == SMAX);
          if (m_take_data && ifc.inst_req) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
          else m_starve = 0;
          m_owner_data = m_take_data;
          if (m_take_data) begin
            m_t.wr = ifc.data_wr; m_t.sel = ifc.data_sel; m_t.addr = ifc.data_addr; m_t.wdata = ifc.data_wdata;
          end else begin
            m_t.wr = 1'b0; m_t.sel = 4'hF; m_t.addr = ifc.inst_addr; m_t.wdata = 32'h0;
          end
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (ifc.bus_addr_ok) begin
          if (ifc.bus_data_ok) m_complete();
          else m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (ifc.bus_data_ok) m_complete();
      end else begin
        m_phase = 0;
      end
    end
  end

  bit cmp_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("busy", 64'(ifc.busy), 64'(m_phase != 0));
      chk("bus_req", 64'(ifc.bus_req), 64'(m_phase == 1));
      chk("inst_data_ok", 64'(ifc.inst_data_ok), 64'(m_iok));
      chk("data_data_ok", 64'(ifc.data_data_ok), 64'(m_dok));
      chk("inst_rdata", 64'(ifc.inst_rdata), 64'(m_irdata));
      chk("data_rdata", 64'(ifc.data_rdata), 64'(m_drdata));
      if (m_phase == 1) begin
        chk("bus_wr", 64'(ifc.bus_wr), 64'(m_t.wr));
        chk("bus_sel", 64'(ifc.bus_sel), 64'(m_t.sel));
        chk("bus_addr", 64'(ifc.bus_addr), 64'(m_t.addr));
        chk("bus_wdata", 64'(ifc.bus_wdata), 64'(m_t.wdata));
      end
    end
  end

  task automatic wait_quiet();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((i_act || d_act || iq.size() > 0 || dq.size() > 0 || ifc.busy) && n < 2000);
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL quiet_timeout actual=busy required=idle cycle=%0d", cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic txn_t mk(input logic wr, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] wd);
    txn_t t;
    t.wr = wr; t.sel = sel; t.addr = a; t.wdata = wd;
    return t;
  endfunction

  // ---------------- directed scenarios ----------------
  int base, d0, i0, n;
  logic [31:0] exp_a;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    chk("rst_bus_req", 64'(ifc.bus_req), 64'd0);
    chk("rst_inst_ok", 64'(ifc.inst_data_ok), 64'd0);
    chk("rst_data_ok", 64'(ifc.data_data_ok), 64'd0);
    chk("rst_inst_rdata", 64'(ifc.inst_rdata), 64'd0);
    chk("rst_data_rdata", 64'(ifc.data_rdata), 64'd0);
    chk("rst_bus_addr", 64'(ifc.bus_addr), 64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // single fetch, zero-wait bus
    base = bus_log.size();
    iq.push_back(32'hBFC0_0000);
    wait_quiet();
    chk("t1_inst_done", 64'(i_done), 64'd1);
    chk("t1_latency", 64'(i_lat), 64'd3);
    chk("t1_inst_rdata", 64'(ifc.inst_rdata), 64'h3C08_8000);
    chk("t1_model_rdata", 64'(m_irdata), 64'h3C08_8000);
    chk("t1_bus_sel", 64'(bus_log[base].sel), 64'hF);
    chk("t1_bus_addr", 64'(bus_log[base].addr), 64'hBFC0_0000);
    chk("t1_data_done", 64'(d_done), 64'd0);

    // simultaneous requests: data first, then fetch
    base = bus_log.size(); d0 = d_done; i0 = i_done;
    dq.push_back(mk(1'b0, 4'hF, 32'h8000_0010, 32'h0));
    iq.push_back(32'hBFC0_0100);
    wait_quiet();
    chk("t2_log_len", 64'(bus_log.size() - base), 64'd2);
    chk("t2_first_addr", 64'(bus_log[base].addr), 64'h8000_0010);
    chk("t2_second_addr", 64'(bus_log[base+1].addr), 64'hBFC0_0100);
    chk("t2_data_rdata", 64'(ifc.data_rdata), 64'hDA5A_0010);
    chk("t2_inst_rdata", 64'(ifc.inst_rdata), 64'hE59A_0100);
    chk("t2_data_done", 64'(d_done - d0), 64'd1);
    chk("t2_inst_done", 64'(i_done - i0), 64'd1);
    chk("t2_data_lat", 64'(d_lat), 64'd3);

    // store: rdata must not change
    base = bus_log.size(); d0 = d_done;
    dq.push_back(mk(1'b1, 4'b0011, 32'h8000_0004, 32'h0000_BEEF));
    wait_quiet();
    chk("t3_bus_wr", 64'(bus_log[base].wr), 64'd1);
    chk("t3_bus_sel", 64'(bus_log[base].sel), 64'h3);
    chk("t3_bus_wdata", 64'(bus_log[base].wdata), 64'h0000_BEEF);
    chk("t3_bus_addr", 64'(bus_log[base].addr), 64'h8000_0004);
    chk("t3_data_done", 64'(d_done - d0), 64'd1);
    chk("t3_data_rdata", 64'(ifc.data_rdata), 64'hDA5A_0010);

    // starvation: 4 data grants, forced fetch, data resumes
    base = bus_log.size();
    iq.push_back(32'hBFC0_0200);
    for (int k = 0; k < 6; k++) dq.push_back(mk(1'b0, 4'hF, 32'h8000_0100 + 32'(4*k), 32'h0));
    wait_quiet();
    chk("t4_log_len", 64'(bus_log.size() - base), 64'd7);
    for (int k = 0; k < 7; k++) begin
      if (k < 4) exp_a = 32'h8000_0100 + 32'(4*k);
      else if (k == 4) exp_a = 32'hBFC0_0200;
      else exp_a = 32'h8000_0100 + 32'(4*(k-1));
      chk("t4_grant_order", 64'(bus_log[base+k].addr), 64'(exp_a));
    end
    chk("t4_model_starve", 64'(m_starve), 64'd0);

    // address stall of 5 cycles, then addr_ok and data_ok together
    addr_wait = 5; same_cycle = 1; d0 = d_done;
    dq.push_back(mk(1'b0, 4'hF, 32'h8000_0200, 32'h0));
    wait_quiet();
    addr_wait = 0; same_cycle = 0;
    chk("t5_req_cycles", 64'(last_req_cycles), 64'd6);
    chk("t5_addr_stable", 64'(last_addr_stable), 64'd1);
    chk("t5_latency", 64'(d_lat), 64'd7);
    chk("t5_data_rdata", 64'(ifc.data_rdata), 64'hDA5A_0200);

    // reset while waiting for data
    data_wait = 1000;
    dq.push_back(mk(1'b0, 4'hF, 32'h8000_0300, 32'h0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ifc.busy && !ifc.bus_req && d_act) && n < 50);
    chk("t6_reached_data", 64'(n < 50), 64'd1);
    rst = 1'b1; d_abort = 1'b1;
    @(negedge clk);
    chk("t6_busy", 64'(ifc.busy), 64'd0);
    chk("t6_bus_req", 64'(ifc.bus_req), 64'd0);
    chk("t6_inst_ok", 64'(ifc.inst_data_ok), 64'd0);
    chk("t6_data_ok", 64'(ifc.data_data_ok), 64'd0);
    @(negedge clk);
    rst = 1'b0; d_abort = 1'b0; data_wait = 0;
    d0 = d_done;
    dq.push_back(mk(1'b0, 4'hF, 32'h8000_0040, 32'h0));
    wait_quiet();
    chk("t6_after_done", 64'(d_done - d0), 64'd1);
    chk("t6_after_lat", 64'(d_lat), 64'd3);
    chk("t6_after_rdata", 64'(ifc.data_rdata), 64'hDA5A_0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
